// File: rtl/binary_arcade_scorer.sv
// Round-based scorer for the binary arcade game: latches a target per round, judges guesses
// under a round timer, keeps saturating score/streak and a life count. Optional macro: STREAK_BONUS_EN.
module binary_arcade_scorer #(
  parameter int WIDTH        = 4,
  parameter int SCORE_W      = 8,
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 4,
  parameter int ROUND_CYCLES = 16,
  parameter int TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   target,
  input  logic [WIDTH-1:0]   guess,
  input  logic               guess_valid,
  output logic [WIDTH-1:0]   round_target,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak,
  output logic [LIVES_W-1:0] lives_left,
  output logic               hit,
  output logic               miss,
  output logic               timeout,
  output logic               playing,
  output logic               game_over
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, OVER} state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(ROUND_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [SCORE_W-1:0] score_nxt, streak_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [WIDTH-1:0]   rt_nxt;
  logic               hit_nxt, miss_nxt, timeout_nxt;
  logic [1:0]         hit_inc;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(inc);
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

`ifdef STREAK_BONUS_EN
  // Bonus is decided on the streak held before this hit is counted.
  assign hit_inc = (streak >= SCORE_W'(3)) ? 2'd2 : 2'd1;
`else
  assign hit_inc = 2'd1;
`endif

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    score_nxt   = score;
    streak_nxt  = streak;
    lives_nxt   = lives_left;
    rt_nxt      = round_target;
    hit_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          score_nxt  = '0;
          streak_nxt = '0;
          lives_nxt  = LIVES_INIT;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        rt_nxt    = target;
        timer_nxt = TIMER_INIT;
        state_nxt = PLAY;
      end
      PLAY: begin
        if (guess_valid && (guess == round_target)) begin
          hit_nxt    = 1'b1;
          score_nxt  = sat_add(score, hit_inc);
          streak_nxt = sat_add(streak, 2'd1);
          state_nxt  = LOAD;
        end else if (guess_valid || (timer == '0)) begin
          // A guess on the last timer cycle takes priority over the timeout.
          miss_nxt    = 1'b1;
          timeout_nxt = !guess_valid;
          streak_nxt  = '0;
          if (lives_left != '0) lives_nxt = lives_left - LIVES_W'(1);
          state_nxt   = (lives_left <= LIVES_W'(1)) ? OVER : LOAD;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      score        <= '0;
      streak       <= '0;
      lives_left   <= LIVES_INIT;
      round_target <= '0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      score        <= score_nxt;
      streak       <= streak_nxt;
      lives_left   <= lives_nxt;
      round_target <= rt_nxt;
      hit          <= hit_nxt;
      miss         <= miss_nxt;
      timeout      <= timeout_nxt;
    end
  end

  assign playing   = (state == LOAD) || (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_binary_arcade_scorer.sv
// Scoreboard bench for binary_arcade_scorer: default instance plus a SCORE_W=2 instance
// driven in lockstep for saturation checks.
module tb_binary_arcade_scorer;

  logic       clk = 1'b0;
  logic       reset, start, guess_valid;
  logic [3:0] target, guess;

  logic [3:0] round_target, lives_left;
  logic [7:0] score, streak;
  logic       hit, miss, timeout, playing, game_over;

  logic [3:0] s_round_target, s_lives_left;
  logic [1:0] s_score, s_streak;
  logic       s_hit, s_miss, s_timeout, s_playing, s_game_over;

  always #5 clk = ~clk;

  binary_arcade_scorer dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .guess(guess),
    .guess_valid(guess_valid), .round_target(round_target), .score(score), .streak(streak),
    .lives_left(lives_left), .hit(hit), .miss(miss), .timeout(timeout),
    .playing(playing), .game_over(game_over)
  );

  binary_arcade_scorer #(.SCORE_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .target(target), .guess(guess),
    .guess_valid(guess_valid), .round_target(s_round_target), .score(s_score),
    .streak(s_streak), .lives_left(s_lives_left), .hit(s_hit), .miss(s_miss),
    .timeout(s_timeout), .playing(s_playing), .game_over(s_game_over)
  );

  typedef struct packed {
    logic [3:0] tgt;
    logic [7:0] sc;
    logic [7:0] sk;
    logic [3:0] lv;
    logic       h, m, t, p, o;
  } obs_t;

  typedef struct packed {
    logic       rst, start;
    logic [3:0] tgt, gs;
    logic       gv;
  } stim_t;

  obs_t       exp_q[$];
  stim_t      stim_q[$];
  logic [3:0] sat_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic obs_t ex(int tgt, int sc, int sk, int lv, int h, int m, int t, int p, int o);
    obs_t e;
    e.tgt = 4'(tgt); e.sc = 8'(sc); e.sk = 8'(sk); e.lv = 4'(lv);
    e.h = 1'(h); e.m = 1'(m); e.t = 1'(t); e.p = 1'(p); e.o = 1'(o);
    return e;
  endfunction

  function automatic stim_t st(int rst, int strt, int tgt, int gs, int gv);
    stim_t s;
    s.rst = 1'(rst); s.start = 1'(strt); s.tgt = 4'(tgt); s.gs = 4'(gs); s.gv = 1'(gv);
    return s;
  endfunction

  function automatic obs_t cap();
    obs_t o;
    o.tgt = round_target; o.sc = score; o.sk = streak; o.lv = lives_left;
    o.h = hit; o.m = miss; o.t = timeout; o.p = playing; o.o = game_over;
    return o;
  endfunction

  task automatic push(stim_t s, obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(stim_t s);
    reset = s.rst; start = s.start; target = s.tgt; guess = s.gs; guess_valid = s.gv;
  endtask

  task automatic test_reset();
    obs_t o, e;
    push(st(1, 0, 0, 0, 0), ex(0, 0, 0, 3, 0, 0, 0, 0, 0));
    push(st(1, 0, 0, 0, 0), ex(0, 0, 0, 3, 0, 0, 0, 0, 0));
    push(st(0, 0, 5, 5, 1), ex(0, 0, 0, 3, 0, 0, 0, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_hit();
    obs_t o, e;
    push(st(0, 1, 9, 0, 0), ex(0, 0, 0, 3, 0, 0, 0, 1, 0));
    push(st(0, 0, 9, 0, 0), ex(9, 0, 0, 3, 0, 0, 0, 1, 0));
    push(st(0, 1, 0, 9, 1), ex(9, 1, 1, 3, 1, 0, 0, 1, 0));  // start ignored in PLAY
    push(st(0, 0, 9, 9, 1), ex(9, 1, 1, 3, 0, 0, 0, 1, 0));  // guess ignored in LOAD
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL hit[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_miss();
    obs_t o, e;
    push(st(0, 0, 0, 8, 1), ex(9, 1, 0, 2, 0, 1, 0, 1, 0));
    push(st(0, 0, 3, 0, 0), ex(3, 1, 0, 2, 0, 0, 0, 1, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL miss[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    for (int k = 0; k < 15; k++) push(st(0, 0, 0, 0, 0), ex(3, 1, 0, 2, 0, 0, 0, 1, 0));
    push(st(0, 0, 0, 0, 0), ex(3, 1, 0, 1, 0, 1, 1, 1, 0));
    push(st(0, 0, 6, 0, 0), ex(6, 1, 0, 1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 15; k++) push(st(0, 0, 0, 0, 0), ex(6, 1, 0, 1, 0, 0, 0, 1, 0));
    push(st(0, 0, 0, 6, 1), ex(6, 2, 1, 1, 1, 0, 0, 1, 0));  // guess on the last PLAY cycle
    push(st(0, 0, 2, 0, 0), ex(2, 2, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL timeout[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_game_over();
    obs_t o, e;
    push(st(0, 0, 0, 7, 1), ex(2, 2, 0, 0, 0, 1, 0, 0, 1));
    push(st(0, 0, 0, 2, 1), ex(2, 2, 0, 0, 0, 0, 0, 0, 1));
    push(st(0, 0, 0, 7, 1), ex(2, 2, 0, 0, 0, 0, 0, 0, 1));
    push(st(0, 1, 1, 0, 0), ex(2, 0, 0, 3, 0, 0, 0, 1, 0));
    push(st(0, 0, 1, 0, 0), ex(1, 0, 0, 3, 0, 0, 0, 1, 0));
    for (int l = 2; l >= 1; l--) begin
      push(st(0, 0, 1, 0, 1), ex(1, 0, 0, l, 0, 1, 0, 1, 0));
      push(st(0, 0, 1, 0, 0), ex(1, 0, 0, l, 0, 0, 0, 1, 0));
    end
    push(st(0, 0, 0, 0, 1), ex(1, 0, 0, 0, 0, 1, 0, 0, 1));
    push(st(0, 0, 0, 1, 1), ex(1, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL game_over[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_round();
    obs_t o, e;
    push(st(0, 1, 4, 0, 0), ex(1, 0, 0, 3, 0, 0, 0, 1, 0));
    push(st(0, 0, 4, 0, 0), ex(4, 0, 0, 3, 0, 0, 0, 1, 0));
    push(st(1, 0, 0, 4, 1), ex(0, 0, 0, 3, 0, 0, 0, 0, 0));
    push(st(0, 0, 0, 4, 1), ex(0, 0, 0, 3, 0, 0, 0, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t       o, e;
    logic [3:0] so, se;
    int         sc[4];
    int         sat_sc[4] = '{1, 2, 3, 3};
`ifdef STREAK_BONUS_EN
    sc = '{1, 2, 3, 5};
`else
    sc = '{1, 2, 3, 4};
`endif
    push(st(0, 1, 10, 0, 0), ex(0, 0, 0, 3, 0, 0, 0, 1, 0));
    sat_q.push_back(4'b0000);
    for (int k = 0; k < 4; k++) begin
      push(st(0, 0, 10 + k, 0, 0), ex(10 + k, (k == 0) ? 0 : sc[k-1], k, 3, 0, 0, 0, 1, 0));
      sat_q.push_back((k == 0) ? 4'b0000 : {2'(sat_sc[k-1]), 2'(sat_sc[k-1])});
      push(st(0, 0, 0, 10 + k, 1), ex(10 + k, sc[k], k + 1, 3, 1, 0, 0, 1, 0));
      sat_q.push_back({2'(sat_sc[k]), 2'(sat_sc[k])});
    end
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front()); @(posedge clk); #1;
      o = cap(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b[%0d] got %h want %h", i, o, e); end
      so = {s_score, s_streak}; se = sat_q.pop_front(); n_cmp++;
      if (so !== se) begin n_bad++; $display("FAIL sat[%0d] got %b want %b", i, so, se); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(st(1, 0, 0, 0, 0));
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_game_over();
    test_reset_mid_round();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
